// File: rtl/cla_pkg.sv
// Shared types and defaults for the frame accumulator and its adder.
package cla_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam int FRAME_LEN_DEF = 4;
    localparam int COUNT_W       = 4;

endpackage

// File: rtl/CLA_16BIT.sv
// Carry-lookahead adder; carries are resolved per 4-bit group from the
// group's incoming carry, so each group's internal carries do not ripple.
module CLA_16BIT #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    logic [WIDTH-1:0] g;
    logic [WIDTH-1:0] p;
    logic [WIDTH:0]   c;

    always_comb begin
        g    = a & b;
        p    = a ^ b;
        c    = '0;
        c[0] = cin;
        for (int i = 0; i < WIDTH; i++) begin
            logic cc;
            cc = c[(i / 4) * 4];
            for (int j = (i / 4) * 4; j <= i; j++) begin
                cc = g[j] | (p[j] & cc);
            end
            c[i + 1] = cc;
        end
        sum = p ^ c[WIDTH-1:0];
    end

    assign cout = c[WIDTH];

endmodule

// File: rtl/cla_accumulator.sv
// Sums FRAME_LEN operands per frame through the CLA and holds the result
// until the downstream handshake.
//
//   state | meaning
//   IDLE  | no operand taken yet in this frame
//   ACCUM | frame in progress, more operands expected
//   HOLD  | result presented, input stalled until out_ready
module cla_accumulator
    import cla_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int FRAME_LEN = FRAME_LEN_DEF
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               clear,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_sum,
    output logic               out_ovf,
    output logic [COUNT_W-1:0] out_count
);

    localparam logic [COUNT_W-1:0] LAST = COUNT_W'(FRAME_LEN);

    state_t             state, state_nxt;
    logic [WIDTH-1:0]   acc, acc_nxt, add_sum;
    logic               ovf, ovf_nxt, add_cout;
    logic [COUNT_W-1:0] count, count_nxt;
    logic               xfer;

    CLA_16BIT #(.WIDTH(WIDTH)) u_cla (
        .a    (acc),
        .b    (in_data),
        .cin  (1'b0),
        .sum  (add_sum),
        .cout (add_cout)
    );

    assign in_ready  = (state != HOLD);
    assign out_valid = (state == HOLD);
    assign out_sum   = acc;
    assign out_ovf   = ovf;
    assign out_count = count;

    always_comb begin
        state_nxt = state;
        acc_nxt   = acc;
        ovf_nxt   = ovf;
        count_nxt = count;
        xfer      = in_valid && in_ready;
        // clear wins over any transfer or handshake in the same cycle
        if (clear) begin
            state_nxt = IDLE;
            acc_nxt   = '0;
            ovf_nxt   = 1'b0;
            count_nxt = '0;
        end else begin
            case (state)
                IDLE, ACCUM: begin
                    if (xfer) begin
                        acc_nxt   = add_sum;
                        ovf_nxt   = ovf | add_cout;
                        count_nxt = count + 1'b1;
                        state_nxt = (count_nxt == LAST) ? HOLD : ACCUM;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state_nxt = IDLE;
                        acc_nxt   = '0;
                        ovf_nxt   = 1'b0;
                        count_nxt = '0;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            acc   <= '0;
            ovf   <= 1'b0;
            count <= '0;
        end else begin
            state <= state_nxt;
            acc   <= acc_nxt;
            ovf   <= ovf_nxt;
            count <= count_nxt;
        end
    end

endmodule
